// File: rtl/vending_pkg.sv
// vending_pkg: shared state type, coin values and price helpers
// for the multi-item vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_e;

  localparam int NICKEL_VAL  = 1;
  localparam int DIME_VAL    = 2;
  localparam int QUARTER_VAL = 5;

  // Upper bound on the packed price vector handled by the helpers.
  localparam int PRICE_VEC_MAX = 1024;

  // Item i costs i+1 units.
  function automatic logic [PRICE_VEC_MAX-1:0] default_prices(
    input int n,
    input int cw
  );
    logic [PRICE_VEC_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = v | (PRICE_VEC_MAX'(i + 1) << (i * cw));
    end
    return v;
  endfunction

  function automatic logic [31:0] price_of(
    input logic [PRICE_VEC_MAX-1:0] prices,
    input int                       idx,
    input int                       cw
  );
    logic [PRICE_VEC_MAX-1:0] sh;
    sh = prices >> (idx * cw);
    return sh[31:0] & ((32'd1 << cw) - 32'd1);
  endfunction

endpackage

// File: rtl/vending_if.sv
// vending_if: coin mechanism / selector / dispenser bundle
// between the machine front end and the controller.
interface vending_if #(
  parameter int ITEM_W   = 4,
  parameter int CREDIT_W = 8
);

  logic [ITEM_W-1:0]   item_number;
  logic                select;
  logic                restock;
  logic                nickel_in;
  logic                dime_in;
  logic                quarter_in;
  logic                cancel;
  logic                dispense;
  logic                nickel_out;
  logic                dime_out;
  logic                coin_reject;
  logic                sold_out;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output item_number, select, restock,
    output nickel_in, dime_in, quarter_in, cancel,
    input  dispense, nickel_out, dime_out,
    input  coin_reject, sold_out, credit, busy
  );

  modport slave (
    input  item_number, select, restock,
    input  nickel_in, dime_in, quarter_in, cancel,
    output dispense, nickel_out, dime_out,
    output coin_reject, sold_out, credit, busy
  );

endinterface

// File: rtl/vending_stock_table.sv
// vending_stock_table: one stock counter per product, with
// restock-to-full and single-step decrement.
module vending_stock_table #(
  parameter int NUM_ITEMS = 16,
  parameter int ITEM_W    = 4,
  parameter int STOCK_W   = 4,
  parameter int MAX_STOCK = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               restock_i,
  input  logic               dec_i,
  input  logic [ITEM_W-1:0]  idx_i,
  input  logic [ITEM_W-1:0]  sel_idx_i,
  output logic [STOCK_W-1:0] stock_o,
  output logic               sel_empty_o
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic               idx_ok;
  logic               sel_ok;

  assign idx_ok = 32'(idx_i) < 32'(NUM_ITEMS);
  assign sel_ok = 32'(sel_idx_i) < 32'(NUM_ITEMS);

  assign stock_o     = idx_ok ? stock_q[idx_i] : '0;
  assign sel_empty_o = !sel_ok ||
                       (stock_q[sel_idx_i] == '0);

  // Counters fill on reset/restock and drop by one per vend.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(MAX_STOCK);
      end
    end else begin
      if (restock_i && idx_ok) begin
        stock_q[idx_i] <= STOCK_W'(MAX_STOCK);
      end
      if (dec_i && sel_ok &&
          stock_q[sel_idx_i] != '0) begin
        stock_q[sel_idx_i] <=
          stock_q[sel_idx_i] - STOCK_W'(1);
      end
    end
  end

endmodule

// File: rtl/vending_controller.sv
// vending_controller: multi-item coin-operated vending FSM with
// per-item prices, stock, cancel/refund and serial change return.
module vending_controller
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS  = 16,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 40,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
    (NUM_ITEMS*CREDIT_W)'(default_prices(NUM_ITEMS, CREDIT_W)),
  parameter int STOCK_W    = 4,
  parameter int MAX_STOCK  = 10
) (
  input logic       clock,
  input logic       reset,
  vending_if.slave  bus
);

  localparam int ITEM_W =
    (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int CW1 = CREDIT_W + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ITEM_W-1:0]   sel_q, sel_d;
  logic                sel_vld_q, sel_vld_d;
  logic                dispense_q, dispense_d;
  logic                nickel_q, nickel_d;
  logic                dime_q, dime_d;
  logic                reject_q, reject_d;
  logic                sold_q, sold_d;
  logic                busy_q, busy_d;

  logic [CW1-1:0]      coin_sum;
  logic [CW1-1:0]      credit_sum;
  logic                any_coin;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic                can_vend;
  logic                item_in_range;
  logic                item_ok;
  logic [STOCK_W-1:0]  item_stock;
  logic                sel_empty;
  logic                restock_en;
  logic                dec_en;
  logic                chg_go;
  logic [CREDIT_W-1:0] chg_amt;

  vending_stock_table #(
    .NUM_ITEMS (NUM_ITEMS),
    .ITEM_W    (ITEM_W),
    .STOCK_W   (STOCK_W),
    .MAX_STOCK (MAX_STOCK)
  ) u_stock (
    .clk_i       (clock),
    .rst_i       (reset),
    .restock_i   (restock_en),
    .dec_i       (dec_en),
    .idx_i       (bus.item_number),
    .sel_idx_i   (sel_q),
    .stock_o     (item_stock),
    .sel_empty_o (sel_empty)
  );

  assign any_coin = bus.nickel_in | bus.dime_in |
                    bus.quarter_in;

  assign coin_sum =
    (bus.nickel_in  ? CW1'(NICKEL_VAL)  : '0) +
    (bus.dime_in    ? CW1'(DIME_VAL)    : '0) +
    (bus.quarter_in ? CW1'(QUARTER_VAL) : '0);

  assign credit_sum = {1'b0, credit_q} + coin_sum;
  assign coin_fits  = credit_sum <= CW1'(MAX_CREDIT);

  assign sel_price = CREDIT_W'(price_of(
    PRICE_VEC_MAX'(PRICES), int'(sel_q), CREDIT_W));

  assign can_vend = sel_vld_q && (credit_q >= sel_price);

  assign item_in_range =
    32'(bus.item_number) < 32'(NUM_ITEMS);
  assign item_ok = item_in_range && (item_stock != '0);

  // Next state, credit, selection and output pulses.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    sel_d      = sel_q;
    sel_vld_d  = sel_vld_q;
    dispense_d = 1'b0;
    nickel_d   = 1'b0;
    dime_d     = 1'b0;
    reject_d   = 1'b0;
    sold_d     = 1'b0;
    restock_en = 1'b0;
    dec_en     = 1'b0;
    chg_go     = 1'b0;
    chg_amt    = credit_q;

    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (bus.cancel) begin
          sel_vld_d = 1'b0;
          reject_d  = any_coin;
          chg_go    = (state_q == S_COLLECT);
        end else if (state_q == S_COLLECT &&
                     can_vend) begin
          reject_d = any_coin;
          if (sel_empty) begin
            sold_d    = 1'b1;
            sel_vld_d = 1'b0;
          end else begin
            state_d    = S_VEND;
            dispense_d = 1'b1;
          end
        end else begin
          if (any_coin) begin
            if (coin_fits) begin
              credit_d = credit_sum[CREDIT_W-1:0];
              state_d  = S_COLLECT;
            end else begin
              reject_d = 1'b1;
            end
          end
          if (bus.select) begin
            if (item_ok) begin
              sel_d     = bus.item_number;
              sel_vld_d = 1'b1;
            end else begin
              sold_d = 1'b1;
            end
          end
          restock_en = (state_q == S_IDLE) &&
                       bus.restock && !any_coin &&
                       !bus.select;
        end
      end
      S_VEND: begin
        reject_d  = any_coin;
        dec_en    = 1'b1;
        sel_vld_d = 1'b0;
        chg_go    = 1'b1;
        chg_amt   = credit_q - sel_price;
      end
      S_CHANGE: begin
        reject_d = any_coin;
        chg_go   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Pay out the first or next change coin, if any is owed.
    if (chg_go) begin
      unique case (1'b1)
        (chg_amt == '0): begin
          state_d  = S_IDLE;
          credit_d = '0;
        end
        (chg_amt >= CREDIT_W'(DIME_VAL)): begin
          state_d  = S_CHANGE;
          dime_d   = 1'b1;
          credit_d = chg_amt - CREDIT_W'(DIME_VAL);
        end
        default: begin
          state_d  = S_CHANGE;
          nickel_d = 1'b1;
          credit_d = chg_amt - CREDIT_W'(NICKEL_VAL);
        end
      endcase
    end

    busy_d = (state_d == S_VEND) ||
             (state_d == S_CHANGE);
  end

  // State, credit, selection and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      sel_q      <= '0;
      sel_vld_q  <= 1'b0;
      dispense_q <= 1'b0;
      nickel_q   <= 1'b0;
      dime_q     <= 1'b0;
      reject_q   <= 1'b0;
      sold_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      sel_q      <= sel_d;
      sel_vld_q  <= sel_vld_d;
      dispense_q <= dispense_d;
      nickel_q   <= nickel_d;
      dime_q     <= dime_d;
      reject_q   <= reject_d;
      sold_q     <= sold_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.dispense    = dispense_q;
  assign bus.nickel_out  = nickel_q;
  assign bus.dime_out    = dime_q;
  assign bus.coin_reject = reject_q;
  assign bus.sold_out    = sold_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;

endmodule
